// File: rtl/cpu_lockstep_checker_pkg.sv
// Shared types for the CPU lockstep checker.
//   bus_txn_t   : one captured bus cycle {addr, data, rw}, 25 bits.
//   chk_state_e : checker FSM states.
//   chk_err_e   : error codes reported on err_code.
package cpu_lockstep_checker_pkg;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
    logic        rw;     // 1 = read
  } bus_txn_t;

  localparam int TXN_W = $bits(bus_txn_t);
  localparam int TMO_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FAIL = 2'd2
  } chk_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISMATCH = 2'd1,
    ERR_OVERFLOW = 2'd2,
    ERR_TIMEOUT  = 2'd3
  } chk_err_e;

endpackage

// File: rtl/cpu_lockstep_checker_txn_fifo.sv
// Small synchronous FIFO of bus transactions, one per checked model.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   push, din  : write din at the edge (ignored when full unless pop)
//   pop        : drop the head entry at the edge
//   flush      : empty the FIFO at the edge (wins over push/pop)
//   full/empty : occupancy flags
//   head       : oldest entry, valid while !empty
module txn_fifo
  import cpu_lockstep_checker_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  logic     pop,
  input  logic     flush,
  input  bus_txn_t din,
  output logic     full,
  output logic     empty,
  output bus_txn_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

  // Extra MSB on each pointer distinguishes full from empty when the
  // index bits are equal.
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  bus_txn_t    mem [DEPTH];
  logic        wr_en;
  logic        rd_en;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);
  assign head  = mem[rd_ptr[AW-1:0]];

  // A push into a full FIFO is only safe when the head leaves on the same edge.
  assign wr_en = push && (!full || pop) && !flush;
  assign rd_en = pop && !empty && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // NOTE: storage is deliberately not reset; the pointers alone define which
  // entries are meaningful, and leaving the array unreset lets it map to RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/cpu_lockstep_checker.sv
// Lockstep checker: buffers bus transactions of a reference CPU model and a
// CPU DUV in per-side FIFOs, compares them in order and latches the first
// divergence (mismatch, FIFO overflow or one-sided timeout).
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   enable                         : checking enabled; low returns to IDLE
//   ref_valid/addr/data/rw         : reference bus cycle
//   duv_valid/addr/data/rw         : DUV bus cycle
//   match_count                    : saturating count of equal pairs
//   error, err_code, err_index     : sticky first-error report
//   err_ref, err_duv               : heads compared at a mismatch
//   busy                           : FSM is in RUN
module cpu_lockstep_checker
  import cpu_lockstep_checker_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             ref_valid,
  input  logic [15:0]      ref_addr,
  input  logic [7:0]       ref_data,
  input  logic             ref_rw,
  input  logic             duv_valid,
  input  logic [15:0]      duv_addr,
  input  logic [7:0]       duv_data,
  input  logic             duv_rw,
  output logic [CNT_W-1:0] match_count,
  output logic             error,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] err_index,
  output logic [TXN_W-1:0] err_ref,
  output logic [TXN_W-1:0] err_duv,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [TMO_W-1:0] TMO_ONE  = TMO_W'(1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  chk_state_e       state, state_nxt;
  chk_err_e         err_q, err_sel;
  logic             active, flush;
  logic             ref_full, ref_empty, duv_full, duv_empty;
  bus_txn_t         ref_head, duv_head, ref_in, duv_in;
  logic             pop, mismatch, overflow, tmo_inc, tmo_hit;
  logic [TMO_W-1:0] tmo_cnt;

  assign ref_in = '{addr: ref_addr, data: ref_data, rw: ref_rw};
  assign duv_in = '{addr: duv_addr, data: duv_data, rw: duv_rw};

  txn_fifo #(.DEPTH(DEPTH)) u_ref_fifo (
    .clk(clk), .rst(rst), .push(active && ref_valid), .pop(pop), .flush(flush),
    .din(ref_in), .full(ref_full), .empty(ref_empty), .head(ref_head)
  );

  txn_fifo #(.DEPTH(DEPTH)) u_duv_fifo (
    .clk(clk), .rst(rst), .push(active && duv_valid), .pop(pop), .flush(flush),
    .din(duv_in), .full(duv_full), .empty(duv_empty), .head(duv_head)
  );

  // Heads are compared and popped together whenever both sides hold data.
  assign pop      = active && !ref_empty && !duv_empty;
  assign mismatch = pop && (ref_head != duv_head);
  assign overflow = active && !pop &&
                    ((ref_valid && ref_full) || (duv_valid && duv_full));
  // pop implies both sides non-empty, so an XOR of the empties already
  // excludes pop cycles.
  assign tmo_inc  = active && (ref_empty != duv_empty);
  assign tmo_hit  = tmo_inc && (tmo_cnt == TMO_LAST);

  always_comb begin
    err_sel = ERR_NONE;
    if      (mismatch) err_sel = ERR_MISMATCH;
    else if (overflow) err_sel = ERR_OVERFLOW;
    else if (tmo_hit)  err_sel = ERR_TIMEOUT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    active    = 1'b0;
    flush     = 1'b0;
    unique case (state)
      IDLE: begin
        flush = 1'b1;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable) begin
          flush     = 1'b1;
          state_nxt = IDLE;
        end else begin
          active = 1'b1;
          if (err_sel != ERR_NONE) state_nxt = FAIL;
        end
      end
      FAIL:    state_nxt = FAIL;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt     <= '0;
      match_count <= '0;
      error       <= 1'b0;
      err_q       <= ERR_NONE;
      err_index   <= '0;
      err_ref     <= '0;
      err_duv     <= '0;
    end else begin
      tmo_cnt <= tmo_inc ? tmo_cnt + TMO_ONE : '0;
      if (pop && !mismatch && (match_count != '1))
        match_count <= match_count + CNT_ONE;
      // Only reachable from RUN, which is left on the first error, so the
      // report always describes the first divergence.
      if (err_sel != ERR_NONE) begin
        error     <= 1'b1;
        err_q     <= err_sel;
        err_index <= match_count;
        if (mismatch) begin
          err_ref <= ref_head;
          err_duv <= duv_head;
        end
      end
    end
  end

  assign err_code = err_q;
  assign busy     = (state == RUN);

endmodule

// File: tb/tb_cpu_lockstep_checker.sv
// Directed self-checking bench for cpu_lockstep_checker (default parameters).
module tb_cpu_lockstep_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        ref_valid, duv_valid;
  logic [15:0] ref_addr, duv_addr;
  logic [7:0]  ref_data, duv_data;
  logic        ref_rw, duv_rw;
  logic [31:0] match_count, err_index;
  logic        error, busy;
  logic [1:0]  err_code;
  logic [24:0] err_ref, err_duv;

  int total = 0;
  int bad   = 0;

  cpu_lockstep_checker #(.DEPTH(8), .TIMEOUT_CYC(64), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .ref_valid(ref_valid), .ref_addr(ref_addr), .ref_data(ref_data), .ref_rw(ref_rw),
    .duv_valid(duv_valid), .duv_addr(duv_addr), .duv_data(duv_data), .duv_rw(duv_rw),
    .match_count(match_count), .error(error), .err_code(err_code),
    .err_index(err_index), .err_ref(err_ref), .err_duv(err_duv), .busy(busy)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs are changed and outputs sampled 1 time unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_ref(input logic v, input logic [15:0] a, input logic [7:0] d, input logic r);
    ref_valid = v; ref_addr = a; ref_data = d; ref_rw = r;
  endtask

  task automatic set_duv(input logic v, input logic [15:0] a, input logic [7:0] d, input logic r);
    duv_valid = v; duv_addr = a; duv_data = d; duv_rw = r;
  endtask

  task automatic do_reset();
    rst = 1'b1; enable = 1'b0;
    set_ref(1'b0, 16'h0, 8'h0, 1'b0);
    set_duv(1'b0, 16'h0, 8'h0, 1'b0);
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_match"}, 64'(match_count), 64'd0);
    check({tag, "_error"}, 64'(error), 64'd0);
    check({tag, "_code"},  64'(err_code), 64'd0);
    check({tag, "_index"}, 64'(err_index), 64'd0);
    check({tag, "_eref"},  64'(err_ref), 64'd0);
    check({tag, "_eduv"},  64'(err_duv), 64'd0);
    check({tag, "_busy"},  64'(busy), 64'd0);
  endtask

  initial begin
    // ---- reset state ----
    do_reset();
    check_cleared("reset");

    // ---- enable -> RUN ----
    enable = 1'b1;
    tick();
    check("run_busy", 64'(busy), 64'd1);

    // ---- 100 identical pairs, same timing ----
    for (int i = 0; i < 100; i++) begin
      set_ref(1'b1, 16'(16'hC000 + i), 8'(i), 1'b1);
      set_duv(1'b1, 16'(16'hC000 + i), 8'(i), 1'b1);
      tick();
    end
    set_ref(1'b0, 16'h0, 8'h0, 1'b0);
    set_duv(1'b0, 16'h0, 8'h0, 1'b0);
    check("lat_99", 64'(match_count), 64'd99);
    tick();
    check("pairs_100", 64'(match_count), 64'd100);
    check("pairs_err", 64'(error), 64'd0);
    check("pairs_busy", 64'(busy), 64'd1);

    // ---- DUV lags 3 cycles, 20 transactions ----
    for (int c = 0; c < 23; c++) begin
      if (c < 20) set_ref(1'b1, 16'(16'h1000 + c), 8'(8'h30 + c), 1'(c % 2));
      else        set_ref(1'b0, 16'h0, 8'h0, 1'b0);
      if (c >= 3) set_duv(1'b1, 16'(16'h1000 + c - 3), 8'(8'h30 + c - 3), 1'((c - 3) % 2));
      else        set_duv(1'b0, 16'h0, 8'h0, 1'b0);
      tick();
    end
    set_duv(1'b0, 16'h0, 8'h0, 1'b0);
    tick(); tick();
    check("skew_match", 64'(match_count), 64'd120);
    check("skew_err", 64'(error), 64'd0);

    // ---- enable dropped with reference entries pending ----
    for (int k = 0; k < 3; k++) begin
      set_ref(1'b1, 16'(16'h2000 + k), 8'h11, 1'b1);
      tick();
    end
    set_ref(1'b0, 16'h0, 8'h0, 1'b0);
    enable = 1'b0;
    tick();
    check("drop_busy", 64'(busy), 64'd0);
    check("drop_match", 64'(match_count), 64'd120);
    check("drop_err", 64'(error), 64'd0);
    enable = 1'b1;
    tick();
    check("reenable_busy", 64'(busy), 64'd1);
    // Stale reference entries would mismatch this DUV entry if not flushed.
    set_duv(1'b1, 16'h3000, 8'h77, 1'b0);
    tick();
    set_duv(1'b0, 16'h0, 8'h0, 1'b0);
    tick(); tick();
    check("flush_err", 64'(error), 64'd0);
    set_ref(1'b1, 16'h3000, 8'h77, 1'b0);
    tick();
    set_ref(1'b0, 16'h0, 8'h0, 1'b0);
    tick();
    check("flush_match", 64'(match_count), 64'd121);

    // ---- push into full reference FIFO while a pop happens: accepted ----
    for (int c = 0; c < 16; c++) begin
      if (c < 9)  set_ref(1'b1, 16'(16'h4000 + c), 8'(c), 1'b1);
      else        set_ref(1'b0, 16'h0, 8'h0, 1'b0);
      if (c >= 7) set_duv(1'b1, 16'(16'h4000 + c - 7), 8'(c - 7), 1'b1);
      else        set_duv(1'b0, 16'h0, 8'h0, 1'b0);
      tick();
      if (c == 8) check("full_pop_err", 64'(error), 64'd0);
    end
    set_duv(1'b0, 16'h0, 8'h0, 1'b0);
    tick(); tick();
    check("full_pop_match", 64'(match_count), 64'd130);
    check("full_pop_err2", 64'(error), 64'd0);

    // ---- DUV answers at cycle 63: no timeout ----
    set_ref(1'b1, 16'h5000, 8'h42, 1'b0);
    tick();
    set_ref(1'b0, 16'h0, 8'h0, 1'b0);
    repeat (62) tick();
    set_duv(1'b1, 16'h5000, 8'h42, 1'b0);
    tick();
    set_duv(1'b0, 16'h0, 8'h0, 1'b0);
    check("tmo63_err", 64'(error), 64'd0);
    tick(); tick();
    check("tmo63_match", 64'(match_count), 64'd131);
    check("tmo63_err2", 64'(error), 64'd0);

    // ---- mismatch on the 7th transaction ----
    do_reset();
    enable = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      set_ref(1'b1, 16'(16'h0100 + i), 8'(8'h10 + i), 1'b1);
      set_duv(1'b1, 16'(16'h0100 + i), 8'(8'h10 + i), 1'b1);
      tick();
    end
    set_ref(1'b1, 16'h0200, 8'hA5, 1'b0);
    set_duv(1'b1, 16'h0200, 8'h5A, 1'b0);
    tick();
    set_ref(1'b0, 16'h0, 8'h0, 1'b0);
    set_duv(1'b0, 16'h0, 8'h0, 1'b0);
    check("mm_pre_err", 64'(error), 64'd0);
    tick();
    check("mm_err", 64'(error), 64'd1);
    check("mm_code", 64'(err_code), 64'd1);
    check("mm_index", 64'(err_index), 64'd6);
    check("mm_eref", 64'(err_ref), 64'({16'h0200, 8'hA5, 1'b0}));
    check("mm_eduv", 64'(err_duv), 64'({16'h0200, 8'h5A, 1'b0}));
    check("mm_match", 64'(match_count), 64'd6);
    check("mm_busy", 64'(busy), 64'd0);
    // FAIL is frozen: further matching traffic must not count.
    set_ref(1'b1, 16'h0300, 8'h01, 1'b1);
    set_duv(1'b1, 16'h0300, 8'h01, 1'b1);
    tick();
    set_ref(1'b0, 16'h0, 8'h0, 1'b0);
    set_duv(1'b0, 16'h0, 8'h0, 1'b0);
    tick(); tick();
    check("fail_frozen", 64'(match_count), 64'd6);
    check("fail_code", 64'(err_code), 64'd1);

    // ---- rst while in FAIL ----
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_cleared("rst_fail");

    // ---- overflow: 9 reference pushes, DUV silent ----
    enable = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      set_ref(1'b1, 16'(16'h6000 + i), 8'(i), 1'b0);
      tick();
      if (i == 7) check("ovf_8_err", 64'(error), 64'd0);
    end
    set_ref(1'b0, 16'h0, 8'h0, 1'b0);
    check("ovf_err", 64'(error), 64'd1);
    check("ovf_code", 64'(err_code), 64'd2);
    check("ovf_index", 64'(err_index), 64'd0);

    // ---- timeout: single reference entry, DUV silent ----
    do_reset();
    enable = 1'b1;
    tick();
    set_ref(1'b1, 16'h7000, 8'h99, 1'b1);
    tick();
    set_ref(1'b0, 16'h0, 8'h0, 1'b0);
    repeat (63) tick();
    check("tmo_63_err", 64'(error), 64'd0);
    tick();
    check("tmo_64_err", 64'(error), 64'd1);
    check("tmo_64_code", 64'(err_code), 64'd3);
    check("tmo_64_busy", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_lockstep_checker.md
Name: cpu_lockstep_checker

Overview:
- Consumes the bus traffic of the CPU reference model and the CPU DUV, which run side by side on identical memory images.
- Buffers each side's bus transactions in a small per-side FIFO, so limited cycle skew between the two models is tolerated.
- Compares transactions in order and latches the first divergence for the coverage and report logic.
- Synthesizable checker instantiated alongside both cpu/mem pairs.

Parameters:
- DEPTH, 8, entries per side FIFO (power of 2, >=2).
- TIMEOUT_CYC, 64, cycles one side may hold entries while the other side's FIFO is empty before a timeout error.
- CNT_W, 32, width of match counter.

Ports:
- clk  in  1  system clock, shared by both models.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  checking enabled; low returns to IDLE.
- ref_valid  in  1  reference bus cycle valid this clock.
- ref_addr  in  16  reference address bus.
- ref_data  in  8  reference data (write data or read return).
- ref_rw  in  1  reference direction, 1=read.
- duv_valid  in  1  DUV bus cycle valid.
- duv_addr  in  16  DUV address bus.
- duv_data  in  8  DUV data.
- duv_rw  in  1  DUV direction, 1=read.
- match_count  out  CNT_W  number of compared-equal transaction pairs.
- error  out  1  sticky; any error detected.
- err_code  out  2  0=none, 1=mismatch, 2=overflow, 3=timeout.
- err_index  out  CNT_W  value of match_count when the error latched.
- err_ref  out  25  {addr,data,rw} of the reference entry at mismatch.
- err_duv  out  25  {addr,data,rw} of the DUV entry at mismatch.
- busy  out  1  state==RUN.

Behaviour:
- Reset: state=IDLE, FIFOs empty, all outputs 0.
- State machine:
  - IDLE: no push, FIFOs held empty. enable=1 -> RUN on next edge.
  - RUN: push on valid, compare and pop. Error -> FAIL. enable=0 -> IDLE; FIFOs flushed; match_count and err_* held.
  - FAIL: no push, no pop; all error outputs frozen. Leaves FAIL only on rst.
- Push: in RUN, a side's valid=1 writes {addr,data,rw} at that edge. The entry is visible (side not empty) the next cycle.
- Compare: in RUN, when both sides are non-empty, the heads are compared combinationally. Both heads pop at that edge.
  - Equal: match_count += 1. Counter saturates at all-ones, with no wrap.
  - Unequal: error=1, err_code=1, err_ref/err_duv=heads, err_index=match_count (pre-increment). -> FAIL.
- Latency: a pair pushed at edge N updates match_count/error at edge N+1, observable 2 cycles after valid.
- Full: push to a full FIFO on the same edge as a pop of that FIFO is accepted. Push to a full FIFO without a pop -> err_code=2, entry dropped -> FAIL.
- Timeout: a 16-bit counter increments each RUN cycle that exactly one FIFO is non-empty and no pop occurs. It clears on pop or when both FIFOs are empty. Reaching TIMEOUT_CYC -> err_code=3 -> FAIL.
- Simultaneous errors in one cycle: priority mismatch > overflow > timeout. err_* record only the first error ever.
- rst mid-operation: immediately returns to reset values at that edge, regardless of state.
- Pointers are log2(DEPTH)+1 bits; full/empty are derived from the MSB compare. Wrap-around is natural modulo.

Decomposition:
- tb_pkg additions:
  - bus_txn_t packed struct {addr[15:0], data[7:0], rw}, 25 bits.
  - chk_state_e {IDLE, RUN, FAIL}.
  - chk_err_e {ERR_NONE, ERR_MISMATCH, ERR_OVERFLOW, ERR_TIMEOUT}.
- Sub-module txn_fifo:
  - Parameterized DEPTH, bus_txn_t payload.
  - Ports: push, pop, flush, full, empty, head.
  - Instantiated twice.

Test Plan:
- Reset, enable, 100 identical pairs with the same valid timing (addr 0xC000+i, data i, rw=1) -> match_count=100, error=0, busy=1.
- DUV delayed 3 cycles vs reference, 20 identical transactions -> match_count=20, no error, no timeout.
- Transaction 7 with DUV data 0x5A vs reference 0xA5 at addr 0x0200 -> error=1, err_code=1, err_index=6, err_ref={0x0200,0xA5,0}, err_duv={0x0200,0x5A,0}, match_count stays 6.
- Reference pushes 9 entries, DUV silent, DEPTH=8 -> err_code=2 on the 9th push. With DUV pushing on that same edge (pop) -> no error.
- Reference pushes 1 entry, DUV silent, TIMEOUT_CYC=64 -> err_code=3 exactly 64 cycles after the entry becomes visible. A DUV push on cycle 63 -> no error.
- rst asserted in FAIL, and enable dropped mid-RUN with entries pending -> all outputs 0 / FIFOs empty and state IDLE next cycle; match_count held after enable drop.
